// File: rtl/chess_pkg.sv
// Shared chess encodings for the move-generation blocks: piece codes,
// colors, move word packing and square index helpers.
package chess_pkg;

    localparam int PIECE_W = 4;
    localparam int MOVE_W  = 12;

    localparam logic [2:0] PT_EMPTY  = 3'd0;
    localparam logic [2:0] PT_PAWN   = 3'd1;
    localparam logic [2:0] PT_KNIGHT = 3'd2;
    localparam logic [2:0] PT_BISHOP = 3'd3;
    localparam logic [2:0] PT_ROOK   = 3'd4;
    localparam logic [2:0] PT_QUEEN  = 3'd5;
    localparam logic [2:0] PT_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    function automatic logic [2:0] sq_row(input logic [5:0] idx);
        return idx[5:3];
    endfunction

    function automatic logic [2:0] sq_col(input logic [5:0] idx);
        return idx[2:0];
    endfunction

    function automatic logic [MOVE_W-1:0] pack_move(
        input logic [2:0] fr,
        input logic [2:0] fc,
        input logic [2:0] tr,
        input logic [2:0] tc
    );
        return {fr, fc, tr, tc};
    endfunction

endpackage

// File: rtl/pawn_push_eval.sv
// Combinational pawn push check for one square: single push qualify,
// double push qualify and the packed move words for both.
module pawn_push_eval
    import chess_pkg::*;
(
    input  logic [PIECE_W-1:0] sq_code,
    input  logic [5:0]         idx,
    input  logic               side,
    input  logic [PIECE_W-1:0] fwd1_code,
    input  logic [PIECE_W-1:0] fwd2_code,
    output logic               qualify,
    output logic               double_qualify,
    output logic [MOVE_W-1:0]  move,
    output logic [MOVE_W-1:0]  dbl_move
);

    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] to1_row;
    logic [2:0] to2_row;
    logic       is_pawn;
    logic       in_range;
    logic       on_start;

    always_comb begin
        row      = sq_row(idx);
        col      = sq_col(idx);
        is_pawn  = (sq_code[2:0] == PT_PAWN) && (sq_code[3] == side);
        if (side == COLOR_WHITE) begin
            in_range = (row != 3'd7);
            on_start = (row == 3'd1);
            to1_row  = row + 3'd1;
            to2_row  = row + 3'd2;
        end else begin
            in_range = (row != 3'd0);
            on_start = (row == 3'd6);
            to1_row  = row - 3'd1;
            to2_row  = row - 3'd2;
        end
        qualify        = is_pawn && in_range
                         && (fwd1_code[2:0] == PT_EMPTY);
        double_qualify = qualify && on_start
                         && (fwd2_code[2:0] == PT_EMPTY);
        move           = pack_move(row, col, to1_row, col);
        dbl_move       = pack_move(row, col, to2_row, col);
    end

endmodule

// File: rtl/pawn_push_gen.sv
// Pawn push move generator: scans a latched board and streams pushes.
// Define PAWN_DOUBLE_PUSH_EN to also emit double pushes from the start rank.
module pawn_push_gen
    import chess_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  side,
    input  logic [255:0]          board_in,
    output logic                  busy,
    output logic                  done,
    output logic                  move_valid,
    output logic [MOVE_W-1:0]     move_data,
    input  logic                  move_ready,
    output logic [CNT_W-1:0]      move_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [255:0]       board_q, board_d;
    logic               side_q, side_d;
    logic [5:0]         idx_q, idx_d;
    logic [MOVE_W-1:0]  move_q, move_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbl_q, dbl_d;

    logic [5:0]         f1_idx;
    logic [5:0]         f2_idx;
    logic               qualify;
    logic               double_qualify;
    logic [MOVE_W-1:0]  ev_move;
    logic [MOVE_W-1:0]  ev_dbl_move;

    // Forward indices may wrap for edge ranks; the eval row check masks that.
    assign f1_idx = side_q ? idx_q - 6'd8  : idx_q + 6'd8;
    assign f2_idx = side_q ? idx_q - 6'd16 : idx_q + 6'd16;

    pawn_push_eval u_eval (
        .sq_code        (board_q[{idx_q, 2'b00} +: PIECE_W]),
        .idx            (idx_q),
        .side           (side_q),
        .fwd1_code      (board_q[{f1_idx, 2'b00} +: PIECE_W]),
        .fwd2_code      (board_q[{f2_idx, 2'b00} +: PIECE_W]),
        .qualify        (qualify),
        .double_qualify (double_qualify),
        .move           (ev_move),
        .dbl_move       (ev_dbl_move)
    );

`ifndef PAWN_DOUBLE_PUSH_EN
    logic unused_dbl;
    assign unused_dbl = ^{double_qualify, ev_dbl_move};
`endif

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        side_d  = side_q;
        idx_d   = idx_q;
        move_d  = move_q;
        cnt_d   = cnt_q;
        dbl_d   = dbl_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    board_d = board_in;
                    side_d  = side;
                    idx_d   = 6'd0;
                    cnt_d   = '0;
                    dbl_d   = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (qualify) begin
                    move_d  = ev_move;
                    state_d = S_EMIT;
                end else if (idx_q == 6'd63) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_EMIT: begin
                if (!start) begin
                    dbl_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (move_ready) begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    dbl_d   = 1'b0;
                    state_d = (idx_q == 6'd63) ? S_DONE : S_SCAN;
                    idx_d   = (idx_q == 6'd63) ? idx_q : idx_q + 6'd1;
`ifdef PAWN_DOUBLE_PUSH_EN
                    if (!dbl_q && double_qualify) begin
                        move_d  = ev_dbl_move;
                        dbl_d   = 1'b1;
                        state_d = S_EMIT;
                        idx_d   = idx_q;
                    end
`endif
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            board_q <= '0;
            side_q  <= 1'b0;
            idx_q   <= 6'd0;
            move_q  <= '0;
            cnt_q   <= '0;
            dbl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            side_q  <= side_d;
            idx_q   <= idx_d;
            move_q  <= move_d;
            cnt_q   <= cnt_d;
            dbl_q   <= dbl_d;
        end
    end

    assign busy       = (state_q == S_SCAN) || (state_q == S_EMIT);
    assign done       = (state_q == S_DONE);
    assign move_valid = (state_q == S_EMIT);
    assign move_data  = move_q;
    assign move_count = cnt_q;

endmodule

// File: tb/tb_pawn_push_gen.sv
// Directed bench for pawn_push_gen: start positions, blocking, backpressure,
// abort and reset, in the default single-push build.
module tb_pawn_push_gen;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         side;
    logic [255:0] board_in;
    logic         busy;
    logic         done;
    logic         move_valid;
    logic [11:0]  move_data;
    logic         move_ready;
    logic [4:0]   move_count;

    int checks = 0;
    int errors = 0;
    int done_at;
    logic [11:0] got_q[$];

    pawn_push_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .side       (side),
        .board_in   (board_in),
        .busy       (busy),
        .done       (done),
        .move_valid (move_valid),
        .move_data  (move_data),
        .move_ready (move_ready),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] init_board();
        logic [255:0] b;
        b = '0;
        b[31:0]    = 32'h42365324;
        b[63:32]   = 32'h11111111;
        b[223:192] = 32'h99999999;
        b[255:224] = 32'hCABEDBAC;
        return b;
    endfunction

    task automatic run_to_done(input int budget);
        got_q.delete();
        done_at = -1;
        start = 1'b1;
        tick();
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (move_valid && move_ready) got_q.push_back(move_data);
            if (done) begin
                done_at = n;
                break;
            end
        end
    endtask

    task automatic end_run();
        start = 1'b0;
        tick();
        chk("done_fall", {31'd0, done}, 32'd0);
    endtask

    task automatic chk_move(input string tag, input int i,
                            input logic [11:0] exp);
        logic [11:0] obs;
        obs = (i < got_q.size()) ? got_q[i] : 12'hxxx;
        chk(tag, {20'd0, obs}, {20'd0, exp});
    endtask

    initial begin
        logic [11:0] white_exp [8];
        logic [255:0] b;
        int n;
        white_exp = '{12'h210, 12'h251, 12'h292, 12'h2D3,
                      12'h314, 12'h355, 12'h396, 12'h3D7};
        reset = 1'b1;
        start = 1'b0;
        side = 1'b0;
        board_in = '0;
        move_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, move_valid}, 32'd0);
        chk("rst_data", {20'd0, move_data}, 32'd0);
        chk("rst_count", {27'd0, move_count}, 32'd0);
        reset = 1'b0;
        tick();

        // White from the initial position
        board_in = init_board();
        side = 1'b0;
        run_to_done(100);
        chk("w_nmoves", got_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) chk_move("w_move", i, white_exp[i]);
        chk("w_count", {27'd0, move_count}, 32'd8);
        chk("w_done_at", done_at, 32'd72);
        end_run();

        // Black from the initial position
        side = 1'b1;
        run_to_done(100);
        chk("b_nmoves", got_q.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk_move("b_move", i, {3'd6, i[2:0], 3'd5, i[2:0]});
        chk_move("b_first", 0, 12'hC28);
        chk_move("b_last", 7, 12'hDEF);
        chk("b_count", {27'd0, move_count}, 32'd8);
        end_run();

        // Empty board
        board_in = '0;
        side = 1'b0;
        run_to_done(100);
        chk("e_nmoves", got_q.size(), 32'd0);
        chk("e_done_at", done_at, 32'd64);
        chk("e_count", {27'd0, move_count}, 32'd0);
        end_run();

        // Pawn blocked by an enemy knight
        b = '0;
        b[4*11 +: 4] = 4'h1;
        b[4*12 +: 4] = 4'h1;
        b[4*19 +: 4] = 4'hA;
        board_in = b;
        side = 1'b0;
        run_to_done(100);
        chk("k_nmoves", got_q.size(), 32'd1);
        chk_move("k_move", 0, 12'h314);
        chk("k_count", {27'd0, move_count}, 32'd1);
        chk("k_done_at", done_at, 32'd65);
        end_run();

        // Backpressure on the first move
        board_in = init_board();
        side = 1'b0;
        move_ready = 1'b0;
        start = 1'b1;
        tick();
        n = 0;
        while (!move_valid && n < 30) begin
            tick();
            n++;
        end
        chk("bp_first_at", n, 32'd9);
        for (int s = 0; s < 10; s++) begin
            if (s > 0) tick();
            chk("bp_valid", {31'd0, move_valid}, 32'd1);
            chk("bp_data", {20'd0, move_data}, 32'h210);
            chk("bp_count", {27'd0, move_count}, 32'd0);
        end
        move_ready = 1'b1;
        tick();
        chk("bp_acc_valid", {31'd0, move_valid}, 32'd0);
        chk("bp_acc_count", {27'd0, move_count}, 32'd1);
        n = 19;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("bp_done_at", n, 32'd81);
        chk("bp_count_end", {27'd0, move_count}, 32'd8);
        end_run();

        // Abort by dropping start at T0+20
        start = 1'b1;
        tick();
        for (int s = 1; s < 20; s++) tick();
        chk("ab_busy", {31'd0, busy}, 32'd1);
        chk("ab_valid_pre", {31'd0, move_valid}, 32'd1);
        start = 1'b0;
        tick();
        chk("ab_busy_post", {31'd0, busy}, 32'd0);
        chk("ab_valid_post", {31'd0, move_valid}, 32'd0);
        chk("ab_count", {27'd0, move_count}, 32'd5);
        tick();
        tick();
        chk("ab_done", {31'd0, done}, 32'd0);

        // Reset in the middle of EMIT
        move_ready = 1'b0;
        start = 1'b1;
        tick();
        n = 0;
        while (!move_valid && n < 30) begin
            tick();
            n++;
        end
        chk("rs_emit", {31'd0, move_valid}, 32'd1);
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_done", {31'd0, done}, 32'd0);
        chk("rs_valid", {31'd0, move_valid}, 32'd0);
        chk("rs_data", {20'd0, move_data}, 32'd0);
        chk("rs_count", {27'd0, move_count}, 32'd0);
        reset = 1'b0;
        move_ready = 1'b1;
        tick();
        run_to_done(100);
        chk_move("rs_first", 0, 12'h210);
        chk("rs_nmoves", got_q.size(), 32'd8);
        chk("rs_done_at", done_at, 32'd72);
        end_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
